// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_pkg
// Description : Shared definitions for the carry-pipelined adder/subtractor.
//               Holds the default operand and segment widths, the operation
//               encoding, the stage-count helper and the parameter legality
//               check used at elaboration time by adder_pipe.
// Revision    : 1.0  initial release
// ============================================================================
package adder_pkg;

   // Default operand width and segment width (one pipeline stage per segment)
   localparam int unsigned DEF_W   = 32;
   localparam int unsigned DEF_SEG = 8;

   // Operation select as seen on the 'sub' input
   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   // Number of pipeline stages for a given width/segment split.
   // A zero segment width is guarded so the division never faults during
   // elaboration; such a configuration is rejected by params_ok anyway.
   function automatic int unsigned num_stages(input int unsigned w,
                                              input int unsigned seg);
      return (seg == 0) ? 1 : (w / seg);
   endfunction

   // Legal configurations: SEG >= 1 and W an exact non-zero multiple of SEG.
   function automatic bit params_ok(input int unsigned w,
                                    input int unsigned seg);
      return (seg >= 1) && (w >= seg) && ((w % seg) == 0);
   endfunction

endpackage : adder_pkg
`default_nettype wire

// File: rtl/adder_seg.sv
`default_nettype none
// ============================================================================
// Module      : adder_seg
// Description : Combinational SEG-bit ripple segment used once per pipeline
//               stage of adder_pipe.
// Ports       : i_a, i_b  segment operands (i_b already inverted for subtract)
//               i_ci      carry into the segment LSB
//               o_s       segment sum
//               o_co      carry out of the segment MSB
//               o_cm      carry into the segment MSB
// Revision    : 1.0  initial release
// ============================================================================
module adder_seg
   import adder_pkg::*;
#(
   parameter int unsigned SEG = DEF_SEG
) (
   input  logic [SEG-1:0] i_a,
   input  logic [SEG-1:0] i_b,
   input  logic           i_ci,
   output logic [SEG-1:0] o_s,
   output logic           o_co,
   output logic           o_cm
);

   logic [SEG:0] w_sum;

   assign w_sum = {1'b0, i_a} + {1'b0, i_b} + {{SEG{1'b0}}, i_ci};
   assign o_s   = w_sum[SEG-1:0];
   assign o_co  = w_sum[SEG];

   // The MSB sum bit is a ^ b ^ carry-in, so the carry into the MSB can be
   // recovered from it without a separate (SEG-1)-bit adder. This form also
   // works for SEG = 1, where the carry into the MSB is simply i_ci.
   assign o_cm  = w_sum[SEG-1] ^ i_a[SEG-1] ^ i_b[SEG-1];

endmodule : adder_seg
`default_nettype wire

// File: rtl/adder_pipe.sv
`default_nettype none
// ============================================================================
// Module      : adder_pipe
// Description : Parametrised carry-pipelined two's-complement adder/subtractor
//               with valid/ready handshakes on both sides. The W-bit operation
//               is split into N = W/SEG segments; segment k is added in stage
//               k using the carry registered by stage k-1, so one operation
//               completes per clock regardless of W. Latency is N cycles.
// Ports       : clk, rst            clock, synchronous active-high reset
//               in_valid, in_ready  operand handshake (in_ready = enable)
//               A, B, c0, sub       operands, carry-in, add(0)/subtract(1)
//               out_valid,out_ready result handshake
//               S, cout, sx         result, MSB carry-out, signed overflow
// Revision    : 1.0  initial release
// ============================================================================
module adder_pipe
   import adder_pkg::*;
#(
   parameter int unsigned W   = DEF_W,
   parameter int unsigned SEG = DEF_SEG
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         c0,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] S,
   output logic         cout,
   output logic         sx
);

   localparam int unsigned N = num_stages(W, SEG);

   generate
      if (!params_ok(W, SEG)) begin : g_param_check
         $error("adder_pipe: W (%0d) must be a non-zero multiple of SEG (%0d)", W, SEG);
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Stage registers
   //   r_ab[k] : A/result merge. Segments 0..k hold finished result bits,
   //             segments above k still hold the untouched A operand. Using a
   //             single vector gives both the A skew and the result de-skew
   //             path; after the last stage it is the whole aligned S.
   //   r_b[k]  : effective B skew. Consumed segments are cleared so only the
   //             operand lanes still needed downstream carry data.
   //   r_cy[k] : carry out of stage k into stage k+1 (last one is cout).
   //   r_vld   : valid shift chain, one bit per stage.
   //   r_sx    : signed overflow captured by the last stage.
   // -------------------------------------------------------------------------
   logic [W-1:0] r_ab [N];
   logic [W-1:0] r_b  [N];
   logic [N-1:0] r_cy;
   logic [N-1:0] r_vld;
   logic         r_sx;

   // Per-stage combinational inputs and next-state values
   logic [W-1:0] w_a_in  [N];
   logic [W-1:0] w_b_in  [N];
   logic         w_c_in  [N];
   logic         w_v_in  [N];
   logic [W-1:0] w_a_nxt [N];
   logic [W-1:0] w_b_nxt [N];
   logic         w_co    [N];
   logic         w_msb_ci;

   logic         w_en;
   op_e          w_op;
   logic [W-1:0] w_b_eff;
   logic         w_ci;

   // Whole-pipe enable: the pipe advances unless a result is waiting at the
   // output and downstream refuses it. Bubbles are deliberately not squeezed
   // out, which keeps in_ready a simple function of the output handshake.
   assign w_en     = !r_vld[N-1] || out_ready;
   assign in_ready = w_en;

   // Subtraction as A + ~B + 1; the borrow-in c0 then flips the carry-in so
   // that A - B - c0 == A + ~B + (1 - c0) == A + ~B + (c0 ^ 1).
   assign w_op    = op_e'(sub);
   assign w_b_eff = B ^ {W{w_op == OP_SUB}};
   assign w_ci    = c0 ^ sub;

   generate
      for (genvar k = 0; k < N; k++) begin : g_stage
         // Bit lanes belonging to segment k
         localparam logic [W-1:0] LANE_MASK = ({W{1'b1}} >> (W - SEG)) << (k * SEG);

         logic [SEG-1:0] w_s;
         logic           w_cm;

         if (k == 0) begin : g_first
            assign w_a_in[k] = A;
            assign w_b_in[k] = w_b_eff;
            assign w_c_in[k] = w_ci;
            assign w_v_in[k] = in_valid;
         end else begin : g_next
            assign w_a_in[k] = r_ab[k-1];
            assign w_b_in[k] = r_b[k-1];
            assign w_c_in[k] = r_cy[k-1];
            assign w_v_in[k] = r_vld[k-1];
         end

         adder_seg #(
            .SEG (SEG)
         ) u_seg (
            .i_a  (w_a_in[k][k*SEG +: SEG]),
            .i_b  (w_b_in[k][k*SEG +: SEG]),
            .i_ci (w_c_in[k]),
            .o_s  (w_s),
            .o_co (w_co[k]),
            .o_cm (w_cm)
         );

         // Drop the new result segment into its lane; retire the B lane.
         assign w_a_nxt[k] = (w_a_in[k] & ~LANE_MASK) | (W'(w_s) << (k * SEG));
         assign w_b_nxt[k] = w_b_in[k] & ~LANE_MASK;

         // Only the top segment's MSB carry-in matters (signed overflow).
         if (k == N - 1) begin : g_last
            assign w_msb_ci = w_cm;
         end else begin : g_mid
            logic w_cm_unused;
            assign w_cm_unused = w_cm;
         end
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Pipeline registers. A stall (w_en = 0) freezes every stage together,
   // so the output beat, its flags and all in-flight beats hold their values.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld <= '0;
         r_cy  <= '0;
         r_sx  <= 1'b0;
         for (int k = 0; k < N; k++) begin
            r_ab[k] <= '0;
            r_b[k]  <= '0;
         end
      end else if (w_en) begin
         for (int k = 0; k < N; k++) begin
            r_ab[k]  <= w_a_nxt[k];
            r_b[k]   <= w_b_nxt[k];
            r_cy[k]  <= w_co[k];
            r_vld[k] <= w_v_in[k];
         end
         r_sx <= w_msb_ci ^ w_co[N-1];
      end
   end

   // Outputs come straight from registers: out_valid has no combinational
   // path from out_ready.
   assign out_valid = r_vld[N-1];
   assign S         = r_ab[N-1];
   assign cout      = r_cy[N-1];
   assign sx        = r_sx;

endmodule : adder_pipe
`default_nettype wire
